calc_seq_engine: RTL and testbench
==================================

Name: calc_seq_engine

Overview:
- Parametrised successor to the calculator control FSM.
- Accepts a serial stream of operands and operators (num op num op … =).
- Dispatches each binary operation to the external ARM-style ALU over a start/done handshake and keeps a running accumulator.
- Presents the final result with flags; adds chain-length limits, ALU timeout and sticky error reporting.

Parameters:
- WIDTH, 32, operand/result width in bits
- OPW, 4, opcode width (ARM data-processing opcode field)
- MAX_OPS, 8, maximum operators accepted per expression
- TIMEOUT, 64, cycles allowed between alu_start and alu_done

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous abort/restart; same effect as rst
- rec_num  in  1  one-cycle strobe: num_in valid
- num_in  in  WIDTH  operand value
- rec_op  in  1  one-cycle strobe: op_in valid
- op_in  in  OPW  operator code
- rec_eq  in  1  one-cycle strobe: evaluate/finish expression
- alu_a  out  WIDTH  ALU operand A (accumulator)
- alu_b  out  WIDTH  ALU operand B
- alu_op  out  OPW  ALU opcode
- alu_start  out  1  one-cycle request pulse
- alu_done  in  1  one-cycle ALU completion pulse
- alu_result  in  WIDTH  ALU result, valid with alu_done
- alu_flags  in  4  NZCV, valid with alu_done
- guarde_num  out  1  one-cycle pulse: operand stored
- lea_result  out  1  one-cycle pulse: result/result_flags valid
- result  out  WIDTH  final value, held until next lea_result
- result_flags  out  4  NZCV of last operation, held
- op_count  out  $clog2(MAX_OPS+1)  operators accepted in current expression
- busy  out  1  high in EXEC
- error  out  1  sticky error
- err_code  out  2  00 none, 01 protocol, 10 chain overflow, 11 ALU timeout

Behaviour:
- Reset (rst or clear, clear equal priority): state IDLE; all outputs 0; acc, pending op, op_count, timeout counter cleared.
- More than one of rec_num/rec_op/rec_eq in a cycle -> ERR, code 01.
- IDLE:
  - rec_num: acc<=num_in, guarde_num next cycle, -> WAIT_OP.
  - rec_op or rec_eq -> ERR 01.
- WAIT_OP:
  - rec_op: if op_count==MAX_OPS -> ERR 10; else pend_op<=op_in, op_count+1, -> WAIT_NUM.
  - rec_eq: result<=acc, lea_result pulse, result_flags unchanged, -> IDLE, op_count<=0.
  - rec_num -> ERR 01.
- WAIT_NUM:
  - rec_num: alu_a<=acc, alu_b<=num_in, alu_op<=pend_op, guarde_num pulse, alu_start pulse next cycle, -> EXEC.
  - rec_op or rec_eq -> ERR 01.
- EXEC:
  - busy=1; timeout counter increments from 0 on the alu_start cycle.
  - alu_done: acc<=alu_result, result_flags<=alu_flags, -> WAIT_OP. Same-cycle strobes ignored.
  - Any strobe before alu_done -> ERR 01.
  - Counter reaching TIMEOUT without alu_done -> ERR 11.
- ERR:
  - error=1, err_code held; all strobes and alu_done ignored.
  - Exit only via rst/clear.
  - result retains its last valid value.
- Latency:
  - strobe -> guarde_num: 1 cycle.
  - rec_num in WAIT_NUM -> alu_start: 1 cycle.
  - rec_eq -> lea_result: 1 cycle.
- alu_a/alu_b/alu_op are held stable from alu_start until alu_done.
- Width: values pass through unmodified; no truncation; arithmetic is owned by the ALU.

Decomposition:
- Package calc_pkg:
  - state encoding (IDLE, WAIT_OP, WAIT_NUM, EXEC, ERR)
  - err_code constants ERR_NONE/ERR_PROTO/ERR_CHAIN/ERR_TIMEOUT
  - NZCV bit indices
- One sub-module: calc_timeout_cnt (load/enable/expired watchdog, parametrised by TIMEOUT).
- Everything else lives in a single FSM.

Test Plan:
- 7, op ADD(0100), 5, eq; ALU model returns a+b after 3 cycles -> alu_a=7, alu_b=5, alu_op=4, one alu_start; then lea_result with result=12, op_count back to 0.
- Chain 10 SUB 3 ADD 4 eq -> two ALU transactions; result=11; guarde_num pulses exactly 3 times.
- MAX_OPS=2: 1 ADD 1 ADD 1 then a third rec_op -> error=1, err_code=10; later strobes ignored; clear -> IDLE, error=0.
- ALU model never asserts alu_done, TIMEOUT=64 -> err_code=11 exactly 64 cycles after alu_start; busy falls.
- Protocol: rec_op in IDLE -> err_code=01; rec_num+rec_op same cycle in WAIT_OP -> err_code=01; rec_num during EXEC -> err_code=01.
- rst asserted mid-EXEC -> next cycle all outputs 0; a subsequent late alu_done is ignored; a fresh expression 2 ADD 2 eq -> result=4.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the serial calculator sequencing engine.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_OP,
        WAIT_NUM,
        EXEC,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PROTO   = 2'b01;
    localparam logic [1:0] ERR_CHAIN   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // NZCV bit positions within a 4-bit flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/calc_timeout_cnt.sv
// Watchdog: load clears the count, en advances it; expired flags the last allowed cycle.
module calc_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Expiring in cycle TIMEOUT-1 lands the error exactly TIMEOUT cycles after the load edge.
    assign expired = en && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/calc_seq_engine.sv
// Serial num/op/eq sequencer driving an external ALU over a start/done handshake.
module calc_seq_engine
    import calc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int MAX_OPS = 8,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             rec_num,
    input  logic [WIDTH-1:0] num_in,
    input  logic             rec_op,
    input  logic [OPW-1:0]   op_in,
    input  logic             rec_eq,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             guarde_num,
    output logic             lea_result,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       result_flags,
    output logic [CW-1:0]    op_count,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [OPW-1:0]   pend_op_q, pend_op_d;
    logic [CW-1:0]    op_count_q, op_count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             alu_start_q, alu_start_d;
    logic             guarde_num_q, guarde_num_d;
    logic             lea_result_q, lea_result_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       result_flags_q, result_flags_d;
    logic [1:0]       err_code_q, err_code_d;

    logic sync_rst, multi, any_strobe, tmo_load, tmo_en, tmo_expired;

    assign sync_rst   = rst | clear;
    assign multi      = multi_strobe(rec_num, rec_op, rec_eq);
    assign any_strobe = rec_num | rec_op | rec_eq;
    assign tmo_en     = (state_q == EXEC) && !alu_done;

    calc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (sync_rst),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        pend_op_d      = pend_op_q;
        op_count_d     = op_count_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        result_d       = result_q;
        result_flags_d = result_flags_q;
        err_code_d     = err_code_q;
        alu_start_d    = 1'b0;
        guarde_num_d   = 1'b0;
        lea_result_d   = 1'b0;
        tmo_load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (multi || rec_op || rec_eq) begin
                    state_d    = ERR;
                    err_code_d = ERR_PROTO;
                end else if (rec_num) begin
                    acc_d        = num_in;
                    guarde_num_d = 1'b1;
                    state_d      = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (multi || rec_num) begin
                    state_d    = ERR;
                    err_code_d = ERR_PROTO;
                end else if (rec_op) begin
                    if (op_count_q == CW'(MAX_OPS)) begin
                        state_d    = ERR;
                        err_code_d = ERR_CHAIN;
                    end else begin
                        pend_op_d  = op_in;
                        op_count_d = op_count_q + 1'b1;
                        state_d    = WAIT_NUM;
                    end
                end else if (rec_eq) begin
                    result_d     = acc_q;
                    lea_result_d = 1'b1;
                    op_count_d   = '0;
                    state_d      = IDLE;
                end
            end
            WAIT_NUM: begin
                if (multi || rec_op || rec_eq) begin
                    state_d    = ERR;
                    err_code_d = ERR_PROTO;
                end else if (rec_num) begin
                    alu_a_d      = acc_q;
                    alu_b_d      = num_in;
                    alu_op_d     = pend_op_q;
                    guarde_num_d = 1'b1;
                    alu_start_d  = 1'b1;
                    tmo_load     = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // A completing ALU wins over any strobe in the same cycle.
                if (alu_done) begin
                    acc_d          = alu_result;
                    result_flags_d = alu_flags;
                    state_d        = WAIT_OP;
                end else if (any_strobe) begin
                    state_d    = ERR;
                    err_code_d = ERR_PROTO;
                end else if (tmo_expired) begin
                    state_d    = ERR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ERR: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            pend_op_q      <= '0;
            op_count_q     <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            alu_start_q    <= 1'b0;
            guarde_num_q   <= 1'b0;
            lea_result_q   <= 1'b0;
            result_q       <= '0;
            result_flags_q <= '0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            pend_op_q      <= pend_op_d;
            op_count_q     <= op_count_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            alu_start_q    <= alu_start_d;
            guarde_num_q   <= guarde_num_d;
            lea_result_q   <= lea_result_d;
            result_q       <= result_d;
            result_flags_q <= result_flags_d;
            err_code_q     <= err_code_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_start    = alu_start_q;
    assign guarde_num   = guarde_num_q;
    assign lea_result   = lea_result_q;
    assign result       = result_q;
    assign result_flags = result_flags_q;
    assign op_count     = op_count_q;
    assign busy         = (state_q == EXEC);
    assign error        = (state_q == ERR);
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed bench for calc_seq_engine with a small 3-cycle ALU responder.
module tb_calc_seq_engine;
    import calc_pkg::*;

    localparam int W  = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1, clear = 1'b0;
    logic          rec_num = 1'b0, rec_op = 1'b0, rec_eq = 1'b0;
    logic [W-1:0]  num_in = '0;
    logic [3:0]    op_in = '0;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_op;
    logic          alu_start;
    logic          alu_done = 1'b0;
    logic [W-1:0]  alu_result = '0;
    logic [3:0]    alu_flags = '0;
    logic          guarde_num, lea_result;
    logic [W-1:0]  result;
    logic [3:0]    result_flags;
    logic [CW-1:0] op_count;
    logic          busy, error;
    logic [1:0]    err_code;

    int n_tests = 0, n_fail = 0;
    int gn_cnt = 0, st_cnt = 0;
    logic alu_en = 1'b1;
    int   dly = 0;
    logic [W-1:0] ma, mb;
    logic [3:0]   mop;

    calc_seq_engine #(.WIDTH(W), .OPW(4), .MAX_OPS(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .rec_num(rec_num), .num_in(num_in), .rec_op(rec_op), .op_in(op_in), .rec_eq(rec_eq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .guarde_num(guarde_num), .lea_result(lea_result), .result(result),
        .result_flags(result_flags), .op_count(op_count), .busy(busy),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD (0100) and SUB (0010) with ARM-style NZCV.
    function automatic logic [35:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
        logic [W:0]   s;
        logic [3:0]   f;
        f = '0;
        if (op == 4'b0010) begin
            s = {1'b0, a} - {1'b0, b};
            f[FLAG_C] = (a >= b);
            f[FLAG_V] = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            f[FLAG_C] = s[W];
            f[FLAG_V] = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        f[FLAG_N] = s[W-1];
        f[FLAG_Z] = (s[W-1:0] == '0);
        return {f, s[W-1:0]};
    endfunction

    always @(negedge clk) begin
        alu_done = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                {alu_flags, alu_result} = alu_calc(ma, mb, mop);
                alu_done = 1'b1;
            end
        end
        if (alu_start && alu_en) begin
            ma = alu_a; mb = alu_b; mop = alu_op; dly = 3;
        end
    end

    always @(posedge clk) begin
        if (guarde_num) gn_cnt <= gn_cnt + 1;
        if (alu_start)  st_cnt <= st_cnt + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_num(input logic [W-1:0] v);
        rec_num = 1'b1; num_in = v;
        @(negedge clk);
        rec_num = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] o);
        rec_op = 1'b1; op_in = o;
        @(negedge clk);
        rec_op = 1'b0;
    endtask

    task automatic send_eq();
        rec_eq = 1'b1;
        @(negedge clk);
        rec_eq = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_alu(input string tag);
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_errcode", {30'd0, err_code}, 0);
        chk("rst_start", {31'd0, alu_start}, 0);
        chk("rst_opcnt", {30'd0, op_count}, 0);

        // 7 + 5
        send_num(32'd7);
        chk("t1_guarde", {31'd0, guarde_num}, 1);
        send_op(4'b0100);
        chk("t1_opcnt", {30'd0, op_count}, 1);
        send_num(32'd5);
        chk("t1_start", {31'd0, alu_start}, 1);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_alu_a", alu_a, 7);
        chk("t1_alu_b", alu_b, 5);
        chk("t1_alu_op", {28'd0, alu_op}, 4);
        @(negedge clk);
        chk("t1_start_pulse", {31'd0, alu_start}, 0);
        chk("t1_alu_a_held", alu_a, 7);
        wait_alu("t1_alu_wait");
        send_eq();
        chk("t1_lea", {31'd0, lea_result}, 1);
        chk("t1_result", result, 12);
        chk("t1_opcnt0", {30'd0, op_count}, 0);
        chk("t1_nstart", st_cnt, 1);
        @(negedge clk);
        chk("t1_lea_pulse", {31'd0, lea_result}, 0);

        // 10 - 3 + 4
        gn_cnt = 0; st_cnt = 0;
        send_num(32'd10);
        send_op(4'b0010);
        send_num(32'd3);
        wait_alu("t2_alu_wait1");
        chk("t2_sub_flags", {28'd0, result_flags}, 32'(1 << FLAG_C));
        send_op(4'b0100);
        send_num(32'd4);
        wait_alu("t2_alu_wait2");
        chk("t2_add_flags", {28'd0, result_flags}, 0);
        send_eq();
        chk("t2_result", result, 11);
        @(negedge clk);
        chk("t2_nguarde", gn_cnt, 3);
        chk("t2_nstart", st_cnt, 2);

        // chain overflow with MAX_OPS=2; result keeps 11 through ERR
        send_num(32'd1);
        send_op(4'b0100);
        send_num(32'd1);
        wait_alu("t3_alu_wait1");
        send_op(4'b0100);
        send_num(32'd1);
        wait_alu("t3_alu_wait2");
        chk("t3_opcnt2", {30'd0, op_count}, 2);
        send_op(4'b0100);
        chk("t3_error", {31'd0, error}, 1);
        chk("t3_errcode", {30'd0, err_code}, 2);
        send_num(32'd9);
        chk("t3_ign_guarde", {31'd0, guarde_num}, 0);
        send_eq();
        chk("t3_ign_lea", {31'd0, lea_result}, 0);
        chk("t3_errcode_held", {30'd0, err_code}, 2);
        chk("t3_result_kept", result, 11);
        do_clear();
        chk("t3_clr_error", {31'd0, error}, 0);
        chk("t3_clr_errcode", {30'd0, err_code}, 0);
        chk("t3_clr_result", result, 0);

        // ALU timeout
        alu_en = 1'b0;
        send_num(32'd5);
        send_op(4'b0100);
        send_num(32'd6);
        chk("t4_start", {31'd0, alu_start}, 1);
        begin
            int k = 0;
            while (err_code != 2'b11 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("t4_tmo_cycles", k, 64);
        end
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_error", {31'd0, error}, 1);
        do_clear();
        alu_en = 1'b1;

        // protocol errors
        send_op(4'b0100);
        chk("t5_op_idle", {30'd0, err_code}, 1);
        do_clear();
        send_num(32'd3);
        rec_num = 1'b1; rec_op = 1'b1;
        @(negedge clk);
        rec_num = 1'b0; rec_op = 1'b0;
        chk("t5_multi", {30'd0, err_code}, 1);
        do_clear();
        send_num(32'd3);
        send_op(4'b0100);
        send_num(32'd4);
        send_num(32'd9);
        chk("t5_num_exec", {30'd0, err_code}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
        repeat (4) @(negedge clk);
        chk("t5_done_ignored", {30'd0, err_code}, 1);
        chk("t5_flags_ignored", {28'd0, result_flags}, 0);
        do_clear();

        // rst in EXEC, late alu_done, then fresh expression
        send_num(32'd8);
        send_op(4'b0100);
        send_num(32'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_alu_op", {28'd0, alu_op}, 0);
        chk("t6_opcnt", {30'd0, op_count}, 0);
        repeat (3) @(negedge clk);
        chk("t6_late_flags", {28'd0, result_flags}, 0);
        chk("t6_late_busy", {31'd0, busy}, 0);
        chk("t6_late_error", {31'd0, error}, 0);
        send_num(32'd2);
        send_op(4'b0100);
        send_num(32'd2);
        wait_alu("t6_alu_wait");
        send_eq();
        chk("t6_result", result, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
